// File: rtl/col16x_dcm_pkg.sv
// rtl/col16x_dcm_pkg.sv - shared types and constants for the col16x DCM sequencer
package col16x_dcm_pkg;

   typedef enum logic [2:0] {
      RESET_DCM = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } dcm_state_t;

   localparam int ST_CLKIN_STOP = 1;
   localparam int ST_CLKFX_STOP = 2;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/col16x_dcm_ctl_bit_sync2.sv
// rtl/col16x_dcm_ctl_bit_sync2.sv - parameterised two-flop synchroniser
module bit_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/col16x_dcm_ctl.sv
// rtl/col16x_dcm_ctl.sv - DCM_SP reset/lock sequencer producing clk_ok for the 16x colour clock
module col16x_dcm_ctl
   import col16x_dcm_pkg::*;
#(
   parameter int RST_CYCLES    = 3,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int SETTLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 7,
   parameter int CNT_W         = 16
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       dcm_locked,
   input  logic [7:0] dcm_status,
   input  logic       restart,
   output logic       dcm_rst,
   output logic       clk_ok,
   output logic       fail,
   output logic [7:0] relock_count,
   output logic [2:0] state_dbg
);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

   dcm_state_t       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [7:0]       retries, retries_d, relock_d;
   logic [2:0]       sync_q;
   logic             lk, bad, retry;
   logic             unused_status;

   assign unused_status = &{1'b0, dcm_status[7:3], dcm_status[0]};

   bit_sync2 #(.W(3)) u_sync (
      .clk   (clk_in),
      .reset (reset),
      .d     ({dcm_status[ST_CLKFX_STOP], dcm_status[ST_CLKIN_STOP], dcm_locked}),
      .q     (sync_q)
   );

   assign lk  = sync_q[0];
   assign bad = !lk | sync_q[1] | sync_q[2];

   always_comb begin
      state_d   = state;
      retries_d = retries;
      relock_d  = relock_count;
      retry     = 1'b0;

      case (state)
         RESET_DCM: if (cnt == RST_LAST) state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            if (lk)                     state_d = SETTLE;
            else if (cnt == LOCK_LAST)  retry   = 1'b1;
         end
         SETTLE: begin
            if (bad) begin
               retry = 1'b1;
            end else if (cnt == SETTLE_LAST) begin
               state_d   = RUN;
               retries_d = '0;
            end
         end
         RUN: begin
            if (bad) begin
               state_d  = RESET_DCM;
               relock_d = sat_inc8(relock_count);
            end
         end
         FAIL:    state_d = FAIL;
         default: state_d = RESET_DCM;
      endcase

      if (retry) begin
         if (retries == RETRY_MAX) begin
            state_d = FAIL;
         end else begin
            retries_d = retries + 8'd1;
            state_d   = RESET_DCM;
         end
      end

      // restart wins over everything but keeps the lock-loss history
      if (restart) begin
         state_d   = RESET_DCM;
         retries_d = '0;
         relock_d  = relock_count;
      end

      cnt_d = (restart || state_d != state) ? '0 : cnt + CNT_W'(1);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state        <= RESET_DCM;
         cnt          <= '0;
         retries      <= '0;
         relock_count <= '0;
         dcm_rst      <= 1'b1;
         clk_ok       <= 1'b0;
         fail         <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         retries      <= retries_d;
         relock_count <= relock_d;
         dcm_rst      <= (state_d == RESET_DCM);
         clk_ok       <= (state_d == RUN);
         fail         <= (state_d == FAIL);
      end
   end

   assign state_dbg = state;

endmodule
